// File: rtl/control_mascara_cargador_if.sv
// Bundle of the instruction-register, coefficient-memory and coefficient-stream signals.
// master = host/memory side, slave = mask loader.
// CONTROL_MASCARA_SUMA_EN adds the suma_coeficientes output.
interface control_mascara_cargador_if #(
  parameter int BITS_BUS_DATOS_INSTR     = 21,
  parameter int BITS_BUS_DIRECCION_INSTR = 11,
  parameter int BITS_DIRECCION_MEM       = 10,
  parameter int BITS_MASCARA             = 3,
  parameter int BITS_COEFICIENTE         = 8,
  parameter int BITS_INDICE              = 6
);
  logic [BITS_BUS_DIRECCION_INSTR-1:0] direccion_registros;
  logic [BITS_BUS_DATOS_INSTR-1:0]     datos_registros;
  logic                                habilitacion_registros;
  logic [BITS_DIRECCION_MEM-1:0]       mem_direccion;
  logic                                mem_lectura;
  logic [BITS_COEFICIENTE-1:0]         mem_datos;
  logic [BITS_COEFICIENTE-1:0]         coef_datos;
  logic [BITS_INDICE-1:0]              coef_indice;
  logic                                coef_valido;
  logic                                mascara_lista;
  logic                                ocupado;
  logic [BITS_MASCARA-1:0]             tamano_mascara;
  logic [BITS_DIRECCION_MEM-1:0]       direccion_mem_inicio_mascara;
  logic                                error_tamano;
`ifdef CONTROL_MASCARA_SUMA_EN
  logic [BITS_COEFICIENTE+5:0]         suma_coeficientes;
`endif

  modport master (
    output direccion_registros, datos_registros, habilitacion_registros, mem_datos,
    input  mem_direccion, mem_lectura, coef_datos, coef_indice, coef_valido,
           mascara_lista, ocupado, tamano_mascara, direccion_mem_inicio_mascara, error_tamano
`ifdef CONTROL_MASCARA_SUMA_EN
    , input suma_coeficientes
`endif
  );

  modport slave (
    input  direccion_registros, datos_registros, habilitacion_registros, mem_datos,
    output mem_direccion, mem_lectura, coef_datos, coef_indice, coef_valido,
           mascara_lista, ocupado, tamano_mascara, direccion_mem_inicio_mascara, error_tamano
`ifdef CONTROL_MASCARA_SUMA_EN
    , output suma_coeficientes
`endif
  );
endinterface

// File: rtl/control_mascara_cargador.sv
// Mask size/base registers plus a sequencer that fetches size*size coefficients and streams them.
// Latency: write cycle t -> first read t+1, first coefficient t+2, mascara_lista t+N+2.
// No backpressure: memory answers in 1 cycle, stream is gapless. Option: CONTROL_MASCARA_SUMA_EN.
module control_mascara_cargador #(
  parameter int BITS_BUS_DATOS_INSTR     = 21,
  parameter int BITS_BUS_DIRECCION_INSTR = 11,
  parameter int BITS_DIRECCION_MEM       = 10,
  parameter int BITS_MASCARA             = 3,
  parameter int BITS_COEFICIENTE         = 8,
  parameter int BITS_INDICE              = 6
) (
  input logic                     clk,
  input logic                     reset,
  control_mascara_cargador_if.slave bus
);
  typedef enum logic [1:0] {REPOSO, LECTURA, DRENAJE} estado_t;

  estado_t                       estado_q, estado_d;
  logic [BITS_MASCARA-1:0]       tamano_q, tamano_d;
  logic [BITS_DIRECCION_MEM-1:0] base_q, base_d;
  logic                          error_q, error_d;
  logic                          lista_q, lista_d;
  logic                          valido_q, valido_d;
  logic [BITS_INDICE-1:0]        k_q, k_d;
  logic [BITS_INDICE-1:0]        indice_q, indice_d;
  logic [BITS_INDICE-1:0]        ultimo;
  logic [BITS_MASCARA-1:0]       tamano_nuevo;
  logic [1:0]                    sel;
  logic                          tamano_ok;
  logic                          disparo;
  logic                          unused_bits;

  assign sel          = bus.direccion_registros[1:0];
  assign tamano_nuevo = bus.datos_registros[BITS_MASCARA-1:0];
  assign tamano_ok    = (tamano_nuevo == BITS_MASCARA'(3)) || (tamano_nuevo == BITS_MASCARA'(5)) ||
                        (tamano_nuevo == BITS_MASCARA'(7));
  // Last index of the mask; size only changes together with a restart, so using the live register is safe.
  assign ultimo       = BITS_INDICE'(tamano_q) * BITS_INDICE'(tamano_q) - BITS_INDICE'(1);
  assign unused_bits  = ^{bus.direccion_registros[BITS_BUS_DIRECCION_INSTR-1:2],
                          bus.datos_registros[BITS_BUS_DATOS_INSTR-1:BITS_DIRECCION_MEM]};

  // Register decode: valid size or any base write triggers a (re)load
  always_comb begin
    tamano_d = tamano_q;
    base_d   = base_q;
    error_d  = error_q;
    disparo  = 1'b0;
    if (bus.habilitacion_registros) begin
      case (sel)
        2'b00: begin
          if (tamano_ok) begin
            tamano_d = tamano_nuevo;
            disparo  = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
        2'b01: begin
          base_d  = bus.datos_registros[BITS_DIRECCION_MEM-1:0];
          disparo = 1'b1;
        end
        2'b10:   error_d = 1'b0;
        default: ;
      endcase
    end
  end

  // Sequencer: a trigger restarts from k=0 and drops the read issued this cycle
  always_comb begin
    estado_d = estado_q;
    k_d      = k_q;
    lista_d  = lista_q;
    valido_d = (estado_q == LECTURA) && !disparo;
    indice_d = valido_d ? k_q : '0;
    if (disparo) begin
      estado_d = LECTURA;
      k_d      = '0;
      lista_d  = 1'b0;
    end else begin
      case (estado_q)
        LECTURA: begin
          if (k_q == ultimo) estado_d = DRENAJE;
          else               k_d = k_q + BITS_INDICE'(1);
        end
        DRENAJE: begin
          estado_d = REPOSO;
          lista_d  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // State and programmable registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q <= REPOSO;
      tamano_q <= BITS_MASCARA'(3);
      base_q   <= '0;
      error_q  <= 1'b0;
      lista_q  <= 1'b0;
      valido_q <= 1'b0;
      k_q      <= '0;
      indice_q <= '0;
    end else begin
      estado_q <= estado_d;
      tamano_q <= tamano_d;
      base_q   <= base_d;
      error_q  <= error_d;
      lista_q  <= lista_d;
      valido_q <= valido_d;
      k_q      <= k_d;
      indice_q <= indice_d;
    end
  end

  assign bus.mem_lectura                  = (estado_q == LECTURA);
  assign bus.mem_direccion                = (estado_q == LECTURA) ? base_q + BITS_DIRECCION_MEM'(k_q) : '0;
  assign bus.coef_valido                  = valido_q;
  assign bus.coef_datos                   = valido_q ? bus.mem_datos : '0;
  assign bus.coef_indice                  = indice_q;
  assign bus.mascara_lista                = lista_q;
  assign bus.ocupado                      = (estado_q != REPOSO);
  assign bus.tamano_mascara               = tamano_q;
  assign bus.direccion_mem_inicio_mascara = base_q;
  assign bus.error_tamano                 = error_q;

`ifdef CONTROL_MASCARA_SUMA_EN
  logic [BITS_COEFICIENTE+5:0] suma_q, suma_d;

  // Running sum of the streamed coefficients, restarted with every load
  always_comb begin
    suma_d = suma_q;
    if (disparo)       suma_d = '0;
    else if (valido_q) suma_d = suma_q + (BITS_COEFICIENTE+6)'(bus.mem_datos);
  end

  // Sum register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) suma_q <= '0;
    else       suma_q <= suma_d;
  end

  assign bus.suma_coeficientes = suma_q;
`endif
endmodule

// File: doc/control_mascara_cargador.md
Name: control_mascara_cargador

Overview:
- Parametrised successor to the mask-control register block: holds mask size and mask base address as instruction-bus programmable registers.
- Adds a sequencer that fetches the mask coefficients (size×size words) from coefficient memory whenever the mask is (re)programmed.
- Streams the coefficients out with their index to the convolution datapath and flags when a complete, consistent mask is loaded.
- Supports 3x3, 5x5 and 7x7 masks.

Parameters:
BITS_BUS_DATOS_INSTR, 21, width of instruction data bus
BITS_BUS_DIRECCION_INSTR, 11, width of instruction register-address bus
BITS_DIRECCION_MEM, 10, coefficient memory address width
BITS_MASCARA, 3, width of mask-size register (holds 3/5/7)
BITS_COEFICIENTE, 8, coefficient word width
BITS_INDICE, 6, coefficient index width (must hold 0..48)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
direccion_registros  in  BITS_BUS_DIRECCION_INSTR  register select; only [1:0] decoded
datos_registros  in  BITS_BUS_DATOS_INSTR  register write data
habilitacion_registros  in  1  write strobe, one cycle per write
mem_direccion  out  BITS_DIRECCION_MEM  coefficient memory read address
mem_lectura  out  1  memory read enable
mem_datos  in  BITS_COEFICIENTE  memory read data, valid exactly 1 cycle after mem_lectura
coef_datos  out  BITS_COEFICIENTE  streamed coefficient
coef_indice  out  BITS_INDICE  row-major index of coef_datos
coef_valido  out  1  coef_datos/coef_indice valid this cycle
mascara_lista  out  1  complete mask loaded for current registers
ocupado  out  1  fetch in progress
tamano_mascara  out  BITS_MASCARA  current mask size
direccion_mem_inicio_mascara  out  BITS_DIRECCION_MEM  current mask base address
error_tamano  out  1  sticky: invalid size was written

Behaviour:
- Reset (async, active-high): tamano_mascara=3, direccion_mem_inicio_mascara=0, all other outputs 0, FSM=REPOSO. Reset mid-fetch aborts immediately; no further coef_valido.
- Register decode when habilitacion_registros=1: [1:0]=00 size, 01 base address, 10 clear error_tamano, 11 ignored. Low bits of datos_registros used; upper bits ignored.
- Size write: value 3, 5 or 7 → register updated, load triggered. Any other value → register unchanged, error_tamano=1 next cycle, no trigger.
- Base write: register updated, load triggered even if value is unchanged (explicit reload).
- N = tamano×tamano (9/25/49). Computed from registered size at trigger time.
- FSM states REPOSO, LECTURA, DRENAJE.
  - REPOSO: trigger → LECTURA next cycle; mascara_lista cleared the cycle after the write.
  - LECTURA: mem_lectura=1, mem_direccion=base+k for k=0..N-1, one per cycle; ocupado=1. After k=N-1 → DRENAJE.
  - DRENAJE: one cycle; final coefficient emitted; → REPOSO, mascara_lista=1 in the following cycle, held until next trigger.
- Coefficient output: in the cycle after read k, coef_valido=1, coef_datos=mem_datos, coef_indice=k. No gaps; exactly N valid beats per completed load.
- Address arithmetic modulo 2^BITS_DIRECCION_MEM (base+k wraps past max to 0).
- Latency: write at edge t → first mem_lectura during cycle t+1 → first coef_valido at t+2 → mascara_lista at t+N+2.
- Trigger during LECTURA/DRENAJE: current fetch aborted. The in-flight beat (read issued previous cycle) is still emitted. Restart at k=0 with the new registers the next cycle; mascara_lista stays 0.
- Size write during a fetch: takes effect on restart only; the aborted fetch never raises mascara_lista.

Optional Feature:
- Macro CONTROL_MASCARA_SUMA_EN.
- Defined:
  - Extra output suma_coeficientes, width BITS_COEFICIENTE+6, unsigned.
  - Cleared on every trigger; accumulates each coef_datos on coef_valido.
  - Final value stable when mascara_lista=1; reset value 0.
- Undefined: port and accumulator absent; behaviour otherwise identical.

Test Plan:
- Reset, then idle 5 cycles → tamano_mascara=3, base=0, mascara_lista=0, mem_lectura=0, error_tamano=0.
- Write size=3 then base=0x010, memory[k]=k+1 → reads 0x010..0x018; coef_indice 0..8, data 1..9 on consecutive cycles; mascara_lista=1 at write+11; suma_coeficientes=45 if enabled.
- Write size=5, base=0x3F0 → 25 reads 0x3F0..0x3FF then 0x000..0x008 (wrap); 25 valid beats, no gaps.
- Write size=4 → tamano_mascara stays 5, error_tamano=1, no mem_lectura. Write reg 10 → error_tamano=0.
- Base=0x100, size=7 load; at read k=10 write base=0x200 → beat k=9 still emitted, then reads restart 0x200, index 0..48; mascara_lista only after 49 new beats.
- Assert reset during LECTURA → all outputs 0 immediately (async), no coef_valido after deassertion until a new write.
